// File: rtl/matmul_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | matmul_pkg : shared types and defaults for matmul_addr_seq         |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
package matmul_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DIM_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr_a;
        logic [DEF_ADDR_W-1:0] addr_b;
        logic [DEF_ADDR_W-1:0] addr_d;
        logic                  first_k;
        logic                  last_k;
    } tuple_t;

endpackage
`default_nettype wire

// File: rtl/matmul_addr_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | matmul_addr_seq_if : address-tuple valid/ready channel             |
// | Revision           : 1.0                                           |
// +--------------------------------------------------------------------+
interface matmul_addr_seq_if
    import matmul_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              addr_valid;
    logic              addr_ready;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [ADDR_W-1:0] addr_d;
    logic              first_k;
    logic              last_k;

    modport master (
        output addr_valid, addr_a, addr_b, addr_d, first_k, last_k,
        input  addr_ready
    );

    modport slave (
        input  addr_valid, addr_a, addr_b, addr_d, first_k, last_k,
        output addr_ready
    );
endinterface
`default_nettype wire

// File: rtl/matmul_addr_seq_loop_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | loop_counter : one loop index; wrap flags the last iteration        |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
module loop_counter
    import matmul_pkg::*;
#(
    parameter int W = DEF_DIM_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         inc,
    input  logic [W-1:0] start_val,
    input  logic [W-1:0] step,
    input  logic [W-1:0] limit,
    output logic [W-1:0] value,
    output logic         wrap
);
    logic [W-1:0] value_q, value_d;
    logic [W:0]   w_sum;

    // Extra bit so value+step never aliases below the limit.
    assign w_sum = {1'b0, value_q} + {1'b0, step};
    assign wrap  = (w_sum >= {1'b0, limit});
    assign value = value_q;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = start_val;
        end else if (inc) begin
            value_d = wrap ? start_val : w_sum[W-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/matmul_addr_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | matmul_addr_seq : i/j/k loop nest emitting (A,B,D) address tuples  |
// | Revision        : 1.0                                              |
// +--------------------------------------------------------------------+
module matmul_addr_seq
    import matmul_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DIM_W     = DEF_DIM_W,
    parameter int NUM_CORES = 1,
    parameter int CORE_ID   = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DIM_W-1:0]  dim_i,
    input  logic [DIM_W-1:0]  dim_j,
    input  logic [DIM_W-1:0]  dim_k,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_d,
    input  logic              b_trans,
    matmul_addr_seq_if.master addr_if,
    output logic              busy,
    output logic              done
);
    localparam logic [DIM_W-1:0] C_CORE_ID   = DIM_W'(CORE_ID);
    localparam logic [DIM_W-1:0] C_NUM_CORES = DIM_W'(NUM_CORES);

    state_e            state_q, state_d;
    logic [DIM_W-1:0]  dim_i_q, dim_i_d, dim_j_q, dim_j_d, dim_k_q, dim_k_d;
    logic [ADDR_W-1:0] base_b_q, base_b_d;
    logic [ADDR_W-1:0] row_a_q, row_a_d, row_d_q, row_d_d, col_b_q, col_b_d;
    logic [ADDR_W-1:0] stride_a_q, stride_a_d, stride_d_q, stride_d_d;
    logic [ADDR_W-1:0] step_b_q, step_b_d, step_col_q, step_col_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d, addr_d_q, addr_d_d;
    logic              valid_q, valid_d, first_k_q, first_k_d, last_k_q, last_k_d;
    logic              busy_q, busy_d, done_q, done_d;

    logic              degenerate, load, adv;
    logic              i_wrap, j_wrap, k_wrap;
    logic [DIM_W-1:0]  i_val, j_val, k_val;
    logic [DIM_W+1:0]  k_plus2;
    logic              unused_cnt;

    assign degenerate = (dim_i == '0) || (dim_j == '0) || (dim_k == '0) || (dim_i <= C_CORE_ID);
    assign load       = (state_q == IDLE) && start && !degenerate;
    assign adv        = (state_q == RUN) && valid_q && addr_if.addr_ready;
    assign k_plus2    = {2'b00, k_val} + (DIM_W+2)'(2);
    assign unused_cnt = ^{i_val, j_val};

    loop_counter #(.W(DIM_W)) u_cnt_i (
        .clock(clock), .reset(reset), .load(load), .inc(adv && k_wrap && j_wrap),
        .start_val(C_CORE_ID), .step(C_NUM_CORES), .limit(dim_i_q),
        .value(i_val), .wrap(i_wrap)
    );

    loop_counter #(.W(DIM_W)) u_cnt_j (
        .clock(clock), .reset(reset), .load(load), .inc(adv && k_wrap),
        .start_val('0), .step(DIM_W'(1)), .limit(dim_j_q),
        .value(j_val), .wrap(j_wrap)
    );

    loop_counter #(.W(DIM_W)) u_cnt_k (
        .clock(clock), .reset(reset), .load(load), .inc(adv),
        .start_val('0), .step(DIM_W'(1)), .limit(dim_k_q),
        .value(k_val), .wrap(k_wrap)
    );

    always_comb begin
        state_d    = state_q;
        dim_i_d    = dim_i_q;    dim_j_d    = dim_j_q;    dim_k_d  = dim_k_q;
        base_b_d   = base_b_q;
        row_a_d    = row_a_q;    row_d_d    = row_d_q;    col_b_d  = col_b_q;
        stride_a_d = stride_a_q; stride_d_d = stride_d_q;
        step_b_d   = step_b_q;   step_col_d = step_col_q;
        addr_a_d   = addr_a_q;   addr_b_d   = addr_b_q;   addr_d_d = addr_d_q;
        valid_d    = valid_q;    first_k_d  = first_k_q;  last_k_d = last_k_q;
        case (state_q)
            IDLE: begin
                if (start && degenerate) begin
                    state_d = FIN;
                end else if (load) begin
                    state_d    = RUN;
                    dim_i_d    = dim_i;
                    dim_j_d    = dim_j;
                    dim_k_d    = dim_k;
                    base_b_d   = base_b;
                    // Constant-factor scaling only; per-step updates are pure adds.
                    stride_a_d = ADDR_W'(NUM_CORES) * ADDR_W'(dim_k);
                    stride_d_d = ADDR_W'(NUM_CORES) * ADDR_W'(dim_j);
                    row_a_d    = base_a + ADDR_W'(CORE_ID) * ADDR_W'(dim_k);
                    row_d_d    = base_d + ADDR_W'(CORE_ID) * ADDR_W'(dim_j);
                    col_b_d    = base_b;
                    step_b_d   = b_trans ? ADDR_W'(1) : ADDR_W'(dim_j);
                    step_col_d = b_trans ? ADDR_W'(dim_k) : ADDR_W'(1);
                    addr_a_d   = row_a_d;
                    addr_b_d   = base_b;
                    addr_d_d   = row_d_d;
                    valid_d    = 1'b1;
                    first_k_d  = 1'b1;
                    last_k_d   = (dim_k == DIM_W'(1));
                end
            end
            RUN: begin
                if (adv) begin
                    if (k_wrap && j_wrap && i_wrap) begin
                        state_d   = FIN;
                        valid_d   = 1'b0;
                        first_k_d = 1'b0;
                        last_k_d  = 1'b0;
                    end else if (!k_wrap) begin
                        addr_a_d  = addr_a_q + ADDR_W'(1);
                        addr_b_d  = addr_b_q + step_b_q;
                        first_k_d = 1'b0;
                        last_k_d  = (k_plus2 >= {2'b00, dim_k_q});
                    end else if (!j_wrap) begin
                        col_b_d   = col_b_q + step_col_q;
                        addr_a_d  = row_a_q;
                        addr_b_d  = col_b_d;
                        addr_d_d  = addr_d_q + ADDR_W'(1);
                        first_k_d = 1'b1;
                        last_k_d  = (dim_k_q == DIM_W'(1));
                    end else begin
                        row_a_d   = row_a_q + stride_a_q;
                        row_d_d   = row_d_q + stride_d_q;
                        col_b_d   = base_b_q;
                        addr_a_d  = row_a_d;
                        addr_b_d  = base_b_q;
                        addr_d_d  = row_d_d;
                        first_k_d = 1'b1;
                        last_k_d  = (dim_k_q == DIM_W'(1));
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            dim_i_q    <= '0; dim_j_q    <= '0; dim_k_q  <= '0;
            base_b_q   <= '0;
            row_a_q    <= '0; row_d_q    <= '0; col_b_q  <= '0;
            stride_a_q <= '0; stride_d_q <= '0;
            step_b_q   <= '0; step_col_q <= '0;
            addr_a_q   <= '0; addr_b_q   <= '0; addr_d_q <= '0;
            valid_q    <= 1'b0; first_k_q <= 1'b0; last_k_q <= 1'b0;
            busy_q     <= 1'b0; done_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dim_i_q    <= dim_i_d;    dim_j_q    <= dim_j_d;    dim_k_q  <= dim_k_d;
            base_b_q   <= base_b_d;
            row_a_q    <= row_a_d;    row_d_q    <= row_d_d;    col_b_q  <= col_b_d;
            stride_a_q <= stride_a_d; stride_d_q <= stride_d_d;
            step_b_q   <= step_b_d;   step_col_q <= step_col_d;
            addr_a_q   <= addr_a_d;   addr_b_q   <= addr_b_d;   addr_d_q <= addr_d_d;
            valid_q    <= valid_d;    first_k_q  <= first_k_d;  last_k_q <= last_k_d;
            busy_q     <= busy_d;     done_q     <= done_d;
        end
    end

    assign addr_if.addr_valid = valid_q;
    assign addr_if.addr_a     = addr_a_q;
    assign addr_if.addr_b     = addr_b_q;
    assign addr_if.addr_d     = addr_d_q;
    assign addr_if.first_k    = first_k_q;
    assign addr_if.last_k     = last_k_q;
    assign busy               = busy_q;
    assign done               = done_q;
endmodule
`default_nettype wire

// File: tb/tb_matmul_addr_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_matmul_addr_seq : directed self-checking bench                  |
// | Revision           : 1.0                                           |
// +--------------------------------------------------------------------+
module tb_matmul_addr_seq;
    import matmul_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic [7:0] dim_i = '0, dim_j = '0, dim_k = '0;
    logic [7:0] base_a = '0, base_b = '0, base_d = '0;
    logic       b_trans = 1'b0;
    logic       ready = 1'b0;
    logic       busy0, done0, busy1, done1;
    bit         sel = 1'b0;

    int         n_checks = 0;
    int         n_errors = 0;
    tuple_t     exp_q[$];

    logic       obs_valid, obs_busy, obs_done;
    tuple_t     obs;

    matmul_addr_seq_if #(.ADDR_W(8)) if0 ();
    matmul_addr_seq_if #(.ADDR_W(8)) if1 ();
    assign if0.addr_ready = ready;
    assign if1.addr_ready = ready;

    matmul_addr_seq #(.ADDR_W(8), .DIM_W(8), .NUM_CORES(1), .CORE_ID(0)) u_dut0 (
        .clock(clock), .reset(reset), .start(start0),
        .dim_i(dim_i), .dim_j(dim_j), .dim_k(dim_k),
        .base_a(base_a), .base_b(base_b), .base_d(base_d), .b_trans(b_trans),
        .addr_if(if0), .busy(busy0), .done(done0)
    );

    matmul_addr_seq #(.ADDR_W(8), .DIM_W(8), .NUM_CORES(2), .CORE_ID(1)) u_dut1 (
        .clock(clock), .reset(reset), .start(start1),
        .dim_i(dim_i), .dim_j(dim_j), .dim_k(dim_k),
        .base_a(base_a), .base_b(base_b), .base_d(base_d), .b_trans(b_trans),
        .addr_if(if1), .busy(busy1), .done(done1)
    );

    always #5 clock = ~clock;

    always_comb begin
        obs_valid = sel ? if1.addr_valid : if0.addr_valid;
        obs_busy  = sel ? busy1 : busy0;
        obs_done  = sel ? done1 : done0;
        obs       = sel ? '{if1.addr_a, if1.addr_b, if1.addr_d, if1.first_k, if1.last_k}
                        : '{if0.addr_a, if0.addr_b, if0.addr_d, if0.first_k, if0.last_k};
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic add(input int a, input int b, input int d, input int f, input int l);
        exp_q.push_back('{8'(a), 8'(b), 8'(d), 1'(f), 1'(l)});
    endtask

    task automatic pulse_start();
        @(negedge clock);
        if (sel) start1 = 1'b1; else start0 = 1'b1;
    endtask

    // Drives ready, checks every presented tuple against exp_q, and
    // returns after stop_after handshakes (full run also checks done).
    task automatic run(input string nm, input bit bp, input int stop_after);
        int idx = 0;
        int cyc = 0;
        int n   = exp_q.size();
        while (idx < stop_after && cyc < 200) begin
            @(negedge clock);
            start0 = 1'b0;
            start1 = 1'b0;
            cyc++;
            ready = bp ? ((cyc % 3) == 1) : 1'b1;
            chk({nm, "_valid"}, int'(obs_valid), 1);
            if (obs_done) chk({nm, "_early_done"}, 1, 0);
            if (obs_valid) begin
                chk({nm, "_a"}, int'(obs.addr_a),  int'(exp_q[idx].addr_a));
                chk({nm, "_b"}, int'(obs.addr_b),  int'(exp_q[idx].addr_b));
                chk({nm, "_d"}, int'(obs.addr_d),  int'(exp_q[idx].addr_d));
                chk({nm, "_f"}, int'(obs.first_k), int'(exp_q[idx].first_k));
                chk({nm, "_l"}, int'(obs.last_k),  int'(exp_q[idx].last_k));
                if (ready) idx++;
            end
        end
        if (idx < stop_after) chk({nm, "_timeout"}, idx, stop_after);
        if (stop_after == n) begin
            @(negedge clock);
            chk({nm, "_done"},       int'(obs_done),  1);
            chk({nm, "_valid_end"},  int'(obs_valid), 0);
            @(negedge clock);
            chk({nm, "_idle_busy"},  int'(obs_busy),  0);
            chk({nm, "_idle_done"},  int'(obs_done),  0);
        end
    endtask

    task automatic degenerate(input string nm);
        pulse_start();
        @(negedge clock);
        start0 = 1'b0;
        start1 = 1'b0;
        chk({nm, "_done"},  int'(obs_done),  1);
        chk({nm, "_valid"}, int'(obs_valid), 0);
        @(negedge clock);
        chk({nm, "_done2"}, int'(obs_done),  0);
        chk({nm, "_busy2"}, int'(obs_busy),  0);
        chk({nm, "_valid2"}, int'(obs_valid), 0);
    endtask

    task automatic load_basic();
        exp_q.delete();
        add(0, 16, 32, 1, 0); add(1, 18, 32, 0, 1);
        add(0, 17, 33, 1, 0); add(1, 19, 33, 0, 1);
        add(2, 16, 34, 1, 0); add(3, 18, 34, 0, 1);
        add(2, 17, 35, 1, 0); add(3, 19, 35, 0, 1);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_valid", int'(if0.addr_valid), 0);
        chk("rst_busy",  int'(busy0), 0);
        chk("rst_done",  int'(done0), 0);
        chk("rst_first", int'(if0.first_k), 0);
        chk("rst_last",  int'(if0.last_k), 0);
        chk("rst_addr",  int'({if0.addr_a, if0.addr_b, if0.addr_d}), 0);

        // Basic 2x2x2
        dim_i = 8'd2; dim_j = 8'd2; dim_k = 8'd2;
        base_a = 8'd0; base_b = 8'd16; base_d = 8'd32; b_trans = 1'b0;
        load_basic();
        pulse_start();
        run("basic", 1'b0, 8);

        // Backpressure with ready 1,0,0 repeating; inputs scrambled after start
        pulse_start();
        @(negedge clock);
        ready = 1'b1;
        chk("bp_first_valid", int'(obs_valid), 1);
        chk("bp_first_a", int'(obs.addr_a), 0);
        start0 = 1'b0;
        dim_i = 8'd9; base_b = 8'd99;
        exp_q.delete();
        add(1, 18, 32, 0, 1);
        add(0, 17, 33, 1, 0); add(1, 19, 33, 0, 1);
        add(2, 16, 34, 1, 0); add(3, 18, 34, 0, 1);
        add(2, 17, 35, 1, 0); add(3, 19, 35, 0, 1);
        run("bp", 1'b1, 7);
        dim_i = 8'd2; base_b = 8'd16;

        // Transposed B
        b_trans = 1'b1;
        exp_q.delete();
        add(0, 16, 32, 1, 0); add(1, 17, 32, 0, 1);
        add(0, 18, 33, 1, 0); add(1, 19, 33, 0, 1);
        add(2, 16, 34, 1, 0); add(3, 17, 34, 0, 1);
        add(2, 18, 35, 1, 0); add(3, 19, 35, 0, 1);
        pulse_start();
        run("trans", 1'b0, 8);
        b_trans = 1'b0;

        // Multi-core: NUM_CORES=2, CORE_ID=1 covers only row 1
        sel = 1'b1;
        dim_i = 8'd3;
        exp_q.delete();
        add(2, 16, 34, 1, 0); add(3, 18, 34, 0, 1);
        add(2, 17, 35, 1, 0); add(3, 19, 35, 0, 1);
        pulse_start();
        run("mc", 1'b0, 4);
        dim_i = 8'd1;
        degenerate("mc_degen");
        sel = 1'b0;

        // Address wrap on D
        dim_i = 8'd1; dim_j = 8'd2; dim_k = 8'd1; base_d = 8'd255;
        exp_q.delete();
        add(0, 16, 255, 1, 1); add(0, 17, 0, 1, 1);
        pulse_start();
        run("wrap", 1'b0, 2);
        dim_k = 8'd0;
        degenerate("k0_degen");

        // Reset mid-run, then a clean restart
        dim_i = 8'd2; dim_j = 8'd2; dim_k = 8'd2; base_d = 8'd32;
        load_basic();
        pulse_start();
        run("pre_rst", 1'b0, 3);
        @(negedge clock);
        ready = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mid_rst_valid", int'(if0.addr_valid), 0);
        chk("mid_rst_busy",  int'(busy0), 0);
        chk("mid_rst_done",  int'(done0), 0);
        repeat (3) begin
            @(negedge clock);
            chk("post_rst_done", int'(done0), 0);
        end
        pulse_start();
        run("restart", 1'b0, 8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/matmul_addr_seq.md
# matmul_addr_seq

Parametrised loop sequencer and address generator for the matrix-multiply core. It replaces the fixed SI/SJ/SK step counters and the combinational AA/AB/AD address calculation with a self-running i/j/k loop nest. The nest handles runtime matrix dimensions, optional transposed-B storage and row striding across several cores. Each cycle it emits one (A, B, D) data-memory address tuple under a valid/ready handshake, together with accumulate-control flags, to the core's datapath and control unit.

## Interface
- ADDR_W, 8, data-memory address width; all address arithmetic is modulo 2^ADDR_W.
- DIM_W, 8, width of each dimension input.
- NUM_CORES, 1, number of cores sharing the matrix; sets the row stride.
- CORE_ID, 0, this core's first row index; must be less than NUM_CORES.

Ports:
- clock  in  1  system clock; one clock only.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- dim_i  in  DIM_W  rows of A and D.
- dim_j  in  DIM_W  columns of B and D.
- dim_k  in  DIM_W  inner dimension.
- base_a / base_b / base_d  in  ADDR_W each  matrix base addresses.
- b_trans  in  1  B is stored column-major.
- addr_valid  out  1  tuple valid.
- addr_ready  in  1  consumer accepts the tuple.
- addr_a / addr_b / addr_d  out  ADDR_W each  current tuple.
- first_k  out  1  k==0; the consumer clears its accumulator.
- last_k  out  1  k==dim_k-1; the consumer writes D after this tuple.
- busy  out  1  not in IDLE.
- done  out  1  one-cycle completion pulse.

## Operation
- State machine has three states: IDLE, RUN and FIN.
- IDLE -> RUN occurs on start.
  - In the same cycle, dims, bases and b_trans are latched.
  - Counters are set to i=CORE_ID, j=0, k=0.
- IDLE -> FIN occurs on start if any dim is 0 or dim_i <= CORE_ID. No tuple is emitted.
- RUN -> FIN occurs on the handshake of the final tuple.
- FIN -> IDLE is unconditional. done=1 only in FIN.
- Loop order is i outermost, then j, then k innermost.
  - i advances by NUM_CORES while i < dim_i.
  - j runs 0..dim_j-1.
  - k runs 0..dim_k-1.
- Address formulas:
  - addr_a = base_a + i*dim_k + k
  - addr_b = base_b + k*dim_j + j, or base_b + j*dim_k + k when b_trans=1
  - addr_d = base_d + i*dim_j + j
- Addresses are maintained incrementally with row-offset registers; no multipliers. Results are truncated to ADDR_W, so wrap past 2^ADDR_W-1 is legal and silent.
- Tuple count = ceil((dim_i-CORE_ID)/NUM_CORES) * dim_j * dim_k.
- Handshake occurs when addr_valid && addr_ready. While addr_valid=1 and addr_ready=0, all outputs hold stable.
- start while busy is ignored; latched values are unaffected.
- Input dims and bases may change freely after the start cycle.
- Reset values: addr_valid=0, busy=0, done=0, first_k=0, last_k=0, addr_*=0, state IDLE.
- Reset mid-run:
  - The run is abandoned.
  - done is never pulsed for it.
  - The next cycle is IDLE with all outputs at reset values.
- Dimensions are treated as unsigned and never saturate.

## Timing
- start at cycle t gives addr_valid=1 with the first tuple at t+1, and busy=1 from t+1.
- With addr_ready held high, throughput is 1 tuple/cycle with no bubbles across k, j or i wrap.
- Final handshake at cycle c: done=1 and addr_valid=0 at c+1, IDLE at c+2. The earliest accepted new start is at c+2.
- Degenerate start at t: done=1 at t+1, with addr_valid never asserted.
- All outputs are registered; there is no combinational path from addr_ready or start to any output.

## Structure
- Package matmul_pkg holds:
  - the state enum (IDLE, RUN, FIN)
  - default ADDR_W and DIM_W constants
  - the tuple struct {addr_a, addr_b, addr_d, first_k, last_k}
- Sub-module loop_counter is instantiated three times. It is parametrised by width, has inputs start value, step, limit and inc, and outputs value and wrap.
- The top level holds the FSM and the three incremental address-offset registers.

## Test plan
- Basic run, NUM_CORES=1, CORE_ID=0, dims 2/2/2, bases 0/16/32, ready high.
  - Exactly 8 tuples are emitted.
  - (a,b,d) sequence: (0,16,32), (1,18,32), (0,17,33), (1,19,33), (2,16,34), (3,18,34), (2,17,35), (3,19,35).
  - first_k is set on even tuples and last_k on odd tuples.
  - done arrives one cycle after the last handshake.
- Backpressure on the same run with addr_ready toggling 1,0,0,1,…
  - Outputs are held during ready-low cycles.
  - The same 8-tuple sequence is emitted with no duplicates or drops.
- Transposed B: b_trans=1 on the same dims.
  - addr_b sequence is 16,17,18,19,16,17,18,19.
- Multi-core: NUM_CORES=2, CORE_ID=1, dims 3/2/2.
  - Only row i=1 is covered: 4 tuples with addr_d 34, 34, 35, 35.
  - Degenerate case with dim_i=1: done at t+1 and no valid.
- Wrap-around: base_d=255, dims 1/2/1.
  - addr_d sequence is 255, 0.
  - dim_k=0 gives done at t+1 with no tuples.
- Reset mid-run: reset asserted after 3 handshakes.
  - The next cycle shows addr_valid=0 and busy=0.
  - done is never seen.
  - A new start then produces the full sequence from tuple 0.
